// File: rtl/dec_jumbo_seq.sv
// dec_jumbo_seq: fetch-to-decode sequencer that merges FA/FB jumbo prefixes
// with the following op into a 64-bit decoder word, with issue statistics.
module dec_jumbo_seq #(
  parameter logic EN_JUMBO  = 1'b1,
  parameter int   CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          fetchWord,
  input  logic                 fetchValid,
  output logic                 fetchReady,
  input  logic                 flush,
  output logic [63:0]          decWord,
  output logic                 decJumbo,
  output logic                 decValid,
  input  logic                 decReady,
  output logic [CNT_WIDTH-1:0] issueCount,
  output logic [CNT_WIDTH-1:0] jumboCount
);
  typedef enum logic {IDLE, PFX} state_t;
  state_t      r_state;
  logic [31:0] r_pfx;
  logic        w_is_pfx;
  logic        w_accept;
  logic        w_issue;
  assign w_is_pfx   = EN_JUMBO && (fetchWord[15:8] == 8'hFA || fetchWord[15:8] == 8'hFB);
  assign fetchReady = (!decValid || decReady) && !flush;
  assign w_accept   = fetchValid && fetchReady;
  assign w_issue    = decValid && decReady;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pfx      <= '0;
      decWord    <= '0;
      decJumbo   <= 1'b0;
      decValid   <= 1'b0;
      issueCount <= '0;
      jumboCount <= '0;
    end else begin
      if (w_issue) begin
        issueCount <= issueCount + 1'b1;
        if (decJumbo) jumboCount <= jumboCount + 1'b1;
      end
      if (flush) begin
        decValid <= 1'b0;
        r_state  <= IDLE;
        r_pfx    <= '0;
      end else if (w_accept && r_state == PFX) begin
        // a second prefix pushes the held one out as a standalone op
        decWord  <= w_is_pfx ? {32'h0, r_pfx} : {r_pfx, fetchWord};
        decJumbo <= !w_is_pfx;
        decValid <= 1'b1;
        r_pfx    <= w_is_pfx ? fetchWord : 32'h0;
        r_state  <= w_is_pfx ? PFX : IDLE;
      end else if (w_accept && !w_is_pfx) begin
        decWord  <= {32'h0, fetchWord};
        decJumbo <= 1'b0;
        decValid <= 1'b1;
      end else begin
        if (w_accept) begin
          r_pfx   <= fetchWord;
          r_state <= PFX;
        end
        if (w_issue) decValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dec_jumbo_seq.sv
// tb_dec_jumbo_seq: directed scenarios plus a randomized stream checked
// against an instruction-stream scoreboard.
module tb_dec_jumbo_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetchWord = '0;
  logic        fetchValid = 1'b0;
  logic        fetchReady;
  logic        flush = 1'b0;
  logic [63:0] decWord;
  logic        decJumbo;
  logic        decValid;
  logic        decReady = 1'b0;
  logic [15:0] issueCount;
  logic [15:0] jumboCount;
  logic [31:0] nj_fetchWord = '0;
  logic        nj_fetchValid = 1'b0;
  logic        nj_fetchReady;
  logic        nj_flush = 1'b0;
  logic [63:0] nj_decWord;
  logic        nj_decJumbo;
  logic        nj_decValid;
  logic        nj_decReady = 1'b0;
  logic [3:0]  nj_issueCount;
  logic [3:0]  nj_jumboCount;
  int checks = 0;
  int errors = 0;
  logic fr_seen;

  always #5 clock = ~clock;

  dec_jumbo_seq dut (
    .clock(clock), .reset(reset), .fetchWord(fetchWord), .fetchValid(fetchValid),
    .fetchReady(fetchReady), .flush(flush), .decWord(decWord), .decJumbo(decJumbo),
    .decValid(decValid), .decReady(decReady), .issueCount(issueCount), .jumboCount(jumboCount)
  );

  dec_jumbo_seq #(.EN_JUMBO(1'b0), .CNT_WIDTH(4)) u_nj (
    .clock(clock), .reset(reset), .fetchWord(nj_fetchWord), .fetchValid(nj_fetchValid),
    .fetchReady(nj_fetchReady), .flush(nj_flush), .decWord(nj_decWord), .decJumbo(nj_decJumbo),
    .decValid(nj_decValid), .decReady(nj_decReady), .issueCount(nj_issueCount), .jumboCount(nj_jumboCount)
  );

  task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
    fetchValid = v;
    fetchWord  = w;
    decReady   = r;
    flush      = f;
    #1 fr_seen = fetchReady;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    fetchValid = 1'b0;
    decReady = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (decValid !== 1'b0 || decWord !== 64'h0 || decJumbo !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b word=%h jumbo=%b want 0/0/0", decValid, decWord, decJumbo);
    end
    checks++;
    if (issueCount !== 16'h0 || jumboCount !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", issueCount, jumboCount);
    end
    reset = 1'b0;
    flush = 1'b0;
    #1;
    checks++;
    if (fetchReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_fetchReady: got %b want 1", fetchReady);
    end
  endtask

  task automatic test_plain();
    apply_reset();
    step(1'b1, 32'h1234F200, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b1 || decWord !== 64'h00000000_1234F200 || decJumbo !== 1'b0) begin
      errors++;
      $display("FAIL plain_first: got valid=%b word=%h jumbo=%b want 1/00000000_1234f200/0", decValid, decWord, decJumbo);
    end
    step(1'b1, 32'h00004801, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b1 || decWord !== 64'h00000000_00004801) begin
      errors++;
      $display("FAIL plain_second: got valid=%b word=%h want 1/00000000_00004801", decValid, decWord);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b0 || issueCount !== 16'd2 || jumboCount !== 16'd0) begin
      errors++;
      $display("FAIL plain_counts: got valid=%b issue=%0d jumbo=%0d want 0/2/0", decValid, issueCount, jumboCount);
    end
  endtask

  task automatic test_jumbo();
    apply_reset();
    step(1'b1, 32'h5678FA12, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b0) begin
      errors++;
      $display("FAIL jumbo_prefix_silent: got valid=%b want 0", decValid);
    end
    step(1'b1, 32'h9ABCF0C5, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b1 || decWord !== 64'h5678FA12_9ABCF0C5 || decJumbo !== 1'b1) begin
      errors++;
      $display("FAIL jumbo_merge: got valid=%b word=%h jumbo=%b want 1/5678fa12_9abcf0c5/1", decValid, decWord, decJumbo);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (issueCount !== 16'd1 || jumboCount !== 16'd1) begin
      errors++;
      $display("FAIL jumbo_counts: got %0d/%0d want 1/1", issueCount, jumboCount);
    end
  endtask

  task automatic test_double_prefix();
    apply_reset();
    step(1'b1, 32'h1111FA01, 1'b1, 1'b0);
    step(1'b1, 32'h2222FB02, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b1 || decWord !== 64'h00000000_1111FA01 || decJumbo !== 1'b0) begin
      errors++;
      $display("FAIL dbl_standalone: got valid=%b word=%h jumbo=%b want 1/00000000_1111fa01/0", decValid, decWord, decJumbo);
    end
    step(1'b1, 32'h3333F200, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b1 || decWord !== 64'h2222FB02_3333F200 || decJumbo !== 1'b1) begin
      errors++;
      $display("FAIL dbl_merge: got valid=%b word=%h jumbo=%b want 1/2222fb02_3333f200/1", decValid, decWord, decJumbo);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (issueCount !== 16'd2 || jumboCount !== 16'd1) begin
      errors++;
      $display("FAIL dbl_counts: got %0d/%0d want 2/1", issueCount, jumboCount);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    step(1'b1, 32'h0000AB01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0000CD02, 1'b0, 1'b0);
      checks++;
      if (fr_seen !== 1'b0 || decValid !== 1'b1 || decWord !== 64'h00000000_0000AB01) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ready=%b valid=%b word=%h want 0/1/00000000_0000ab01", i, fr_seen, decValid, decWord);
      end
    end
    step(1'b1, 32'h0000CD02, 1'b1, 1'b0);
    checks++;
    if (fr_seen !== 1'b1 || decValid !== 1'b1 || decWord !== 64'h00000000_0000CD02 || issueCount !== 16'd1) begin
      errors++;
      $display("FAIL stall_release: got ready=%b valid=%b word=%h issue=%0d want 1/1/00000000_0000cd02/1", fr_seen, decValid, decWord, issueCount);
    end
  endtask

  task automatic test_flush_pfx();
    apply_reset();
    step(1'b1, 32'hAAAAFA00, 1'b1, 1'b0);
    step(1'b1, 32'h00000001, 1'b1, 1'b1);
    checks++;
    if (fr_seen !== 1'b0 || decValid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: got ready=%b valid=%b want 0/0", fr_seen, decValid);
    end
    step(1'b1, 32'h0000F200, 1'b1, 1'b0);
    checks++;
    if (decValid !== 1'b1 || decWord !== 64'h00000000_0000F200 || decJumbo !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got valid=%b word=%h jumbo=%b want 1/00000000_0000f200/0", decValid, decWord, decJumbo);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (issueCount !== 16'd1 || jumboCount !== 16'd0) begin
      errors++;
      $display("FAIL flush_counts: got %0d/%0d want 1/0", issueCount, jumboCount);
    end
  endtask

  task automatic test_nojumbo_wrap();
    apply_reset();
    nj_decReady = 1'b1;
    for (int i = 0; i < 18; i++) begin
      nj_fetchValid = (i < 17);
      nj_fetchWord  = (i % 2 == 0) ? 32'h5678FA12 : 32'h9ABCF0C5;
      @(posedge clock);
      #1;
      if (i == 0) begin
        checks++;
        if (nj_decValid !== 1'b1 || nj_decWord !== 64'h00000000_5678FA12 || nj_decJumbo !== 1'b0) begin
          errors++;
          $display("FAIL nj_standalone: got valid=%b word=%h jumbo=%b want 1/00000000_5678fa12/0", nj_decValid, nj_decWord, nj_decJumbo);
        end
      end
    end
    checks++;
    if (nj_issueCount !== 4'd1 || nj_jumboCount !== 4'd0) begin
      errors++;
      $display("FAIL nj_wrap: got %0d/%0d want 1/0", nj_issueCount, nj_jumboCount);
    end
    nj_fetchValid = 1'b0;
    nj_decReady = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b1, 32'h00001111, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (decValid !== 1'b0 || decWord !== 64'h0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b word=%h want 0/0", decValid, decWord);
    end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_random();
    logic [64:0] q[$];
    logic [31:0] pend;
    logic        pend_v;
    int          n_iss;
    int          n_jmb;
    logic        v, r, f, exp_fr, acc, pfx;
    logic [31:0] w;
    apply_reset();
    pend_v = 1'b0;
    pend = '0;
    n_iss = 0;
    n_jmb = 0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      f = ($urandom % 20) == 0;
      w = $urandom;
      if ($urandom % 3 == 0) w[15:8] = ($urandom % 2) ? 8'hFA : 8'hFB;
      fetchValid = v;
      fetchWord = w;
      decReady = r;
      flush = f;
      #1;
      exp_fr = (q.size() == 0 || r) && !f;
      checks++;
      if (fetchReady !== exp_fr || decValid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_hs[%0d]: got ready=%b valid=%b want %b/%b", c, fetchReady, decValid, exp_fr, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if ({decJumbo, decWord} !== q[0]) begin
          errors++;
          $display("FAIL rand_word[%0d]: got jumbo=%b word=%h want %b/%h", c, decJumbo, decWord, q[0][64], q[0][63:0]);
        end
      end
      acc = v && exp_fr;
      pfx = (w[15:8] == 8'hFA || w[15:8] == 8'hFB);
      if (q.size() != 0 && r) begin
        n_iss++;
        if (q[0][64]) n_jmb++;
        void'(q.pop_front());
      end
      if (f) begin
        q.delete();
        pend_v = 1'b0;
      end else if (acc) begin
        if (pfx) begin
          if (pend_v) q.push_back({1'b0, 32'h0, pend});
          pend = w;
          pend_v = 1'b1;
        end else if (pend_v) begin
          q.push_back({1'b1, pend, w});
          pend_v = 1'b0;
        end else q.push_back({1'b0, 32'h0, w});
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (issueCount !== n_iss[15:0] || jumboCount !== n_jmb[15:0]) begin
      errors++;
      $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", issueCount, jumboCount, n_iss, n_jmb);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_jumbo();
    test_double_prefix();
    test_stall();
    test_flush_pfx();
    test_nojumbo_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
